// File: rtl/ufc_pkg.sv
// Shared constants for the UFC FIFO bridge: TX FSM encoding, ERR bit layout
// and the TVALID stall limit.
package ufc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  localparam int ERR_FULL_BIT  = 0;
  localparam int ERR_STALL_BIT = 1;

  localparam int               STALL_W     = 11;
  localparam logic [STALL_W-1:0] STALL_LIMIT = 11'd1024;

  // Index width that never collapses to zero bits for single-entry arrays.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ufc_pack_buf.sv
// Word-addressed pack buffer for one UFC message, read back one beat at a time.
// Slot w lands in beat w/WPB at lane w%WPB; clearing zeroes every slot.
module ufc_pack_buf
  import ufc_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH   = 32,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int MAX_BEATS         = 4,
  localparam int WPB       = AURORA_DATA_WIDTH / FIFO_DATA_WIDTH,
  localparam int MAX_WORDS = MAX_BEATS * WPB,
  localparam int SLOT_W    = clog2_min1(MAX_WORDS),
  localparam int BEAT_W    = clog2_min1(MAX_BEATS)
) (
  input  logic                         clk_i,
  input  logic                         clr_i,
  input  logic                         wr_en_i,
  input  logic [SLOT_W-1:0]            wr_slot_i,
  input  logic [FIFO_DATA_WIDTH-1:0]   wr_data_i,
  input  logic [BEAT_W-1:0]            rd_beat_i,
  output logic [AURORA_DATA_WIDTH-1:0] rd_data_o
);

  logic [FIFO_DATA_WIDTH-1:0] slot_q [MAX_WORDS];

  // NOTE: the slot array has no reset branch; the owner pulses clr_i (also
  // during reset) so unused lanes of a short last beat read back as zero.
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < MAX_WORDS; w++) begin
      if (clr_i) begin
        slot_q[w] <= '0;
      end else if (wr_en_i && (int'(wr_slot_i) == w)) begin
        slot_q[w] <= wr_data_i;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int w = 0; w < MAX_WORDS; w++) begin
      if ((w / WPB) == int'(rd_beat_i)) begin
        rd_data_o[(w % WPB)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] = slot_q[w];
      end
    end
  end

endmodule

// File: rtl/ufc_fifo_bridge.sv
// Bridges an Aurora UFC link to a pair of word FIFOs: RX beats pass straight
// through, TX words are packed into UFC messages and flushed when full or idle.
module ufc_fifo_bridge
  import ufc_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH   = 32,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int MAX_BEATS         = 4,
  parameter int FLUSH_TIMEOUT     = 16
) (
  input  logic                           AURORA_USER_CLK,
  input  logic                           RESET,
  output logic                           AURORA_TX_REQ,
  output logic [7:0]                     AURORA_TX_MS,
  input  logic                           AURORA_TX_TREADY,
  output logic [AURORA_DATA_WIDTH-1:0]   AURORA_TX_TDATA,
  output logic                           AURORA_TX_TVALID,
  input  logic [AURORA_DATA_WIDTH-1:0]   AURORA_RX_TDATA,
  input  logic [AURORA_DATA_WIDTH/8-1:0] AURORA_RX_TKEEP,
  input  logic                           AURORA_RX_TVALID,
  output logic                           FIFO_CLK,
  output logic [AURORA_DATA_WIDTH-1:0]   TX_FIFO_Q,
  output logic [5:0]                     TX_FIFO_NWORDS,
  output logic                           TX_FIFO_WREN,
  input  logic                           TX_FIFO_FULL,
  input  logic [FIFO_DATA_WIDTH-1:0]     RX_FIFO_Q,
  output logic                           RX_FIFO_RDEN,
  input  logic                           RX_FIFO_EMPTY,
  input  logic                           ERR_CLR,
  output logic [1:0]                     ERR,
  output logic [15:0]                    MSG_CNT
);

  localparam int WPB       = AURORA_DATA_WIDTH / FIFO_DATA_WIDTH;
  localparam int BPW       = FIFO_DATA_WIDTH / 8;
  localparam int MAX_WORDS = MAX_BEATS * WPB;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int IDLE_W    = $clog2(FLUSH_TIMEOUT + 1);
  localparam int SLOT_W    = clog2_min1(MAX_WORDS);
  localparam int BEAT_W    = clog2_min1(MAX_BEATS);
  localparam logic [CNT_W-1:0]  MAX_WORDS_C = CNT_W'(MAX_WORDS);
  localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(FLUSH_TIMEOUT);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [BEAT_W-1:0]  beat_q, beat_d, last_beat;
  logic               tvalid_q, tvalid_d;
  logic [7:0]         ms_q, ms_d;
  logic [15:0]        msg_cnt_q, msg_cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [1:0]         err_q, err_d, err_set;
  logic               buf_clr;
  logic               rden;

  // RX path is a pure passthrough; word count is ceil(kept bytes / bytes per word).
  assign FIFO_CLK     = AURORA_USER_CLK;
  assign TX_FIFO_Q    = AURORA_RX_TDATA;
  assign TX_FIFO_WREN = AURORA_RX_TVALID;

  always_comb begin
    int ones;
    ones = 0;
    for (int i = 0; i < AURORA_DATA_WIDTH/8; i++) ones += int'(AURORA_RX_TKEEP[i]);
    TX_FIFO_NWORDS = 6'((ones + BPW - 1) / BPW);
  end

  assign rden = !RESET && (state_q == ST_FILL) && !RX_FIFO_EMPTY && (count_q < MAX_WORDS_C);
  assign RX_FIFO_RDEN     = rden;
  assign last_beat        = BEAT_W'((int'(count_q) + WPB - 1) / WPB - 1);
  assign AURORA_TX_REQ    = (state_q == ST_REQ);
  assign AURORA_TX_MS     = ms_q;
  assign AURORA_TX_TVALID = tvalid_q;
  assign MSG_CNT          = msg_cnt_q;
  assign ERR              = err_q;

  // NOTE: every next-state variable takes its held value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idle_d    = idle_q;
    beat_d    = beat_q;
    tvalid_d  = tvalid_q;
    ms_d      = ms_q;
    msg_cnt_d = msg_cnt_q;
    buf_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!RX_FIFO_EMPTY) begin
          state_d = ST_FILL;
          count_d = '0;
          idle_d  = '0;
          beat_d  = '0;
          buf_clr = 1'b1;
        end
      end
      ST_FILL: begin
        if (rden) begin
          count_d = count_q + 1'b1;
          idle_d  = '0;
        end else if (idle_q != IDLE_MAX) begin
          idle_d = idle_q + 1'b1;
        end
        // Leave on the same edge that fills the buffer or expires the timer.
        if ((count_d == MAX_WORDS_C) || ((count_d != '0) && (idle_d == IDLE_MAX))) begin
          state_d = ST_REQ;
          ms_d    = 8'(int'(count_d) * BPW - 1);
        end
      end
      ST_REQ: begin
        state_d  = ST_SEND;
        tvalid_d = 1'b1;
        beat_d   = '0;
      end
      ST_SEND: begin
        if (AURORA_TX_TREADY) begin
          if (beat_q == last_beat) begin
            state_d   = ST_IDLE;
            tvalid_d  = 1'b0;
            msg_cnt_d = msg_cnt_q + 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky errors: a set in the same cycle as ERR_CLR survives the clear.
  always_comb begin
    stall_d = '0;
    if (tvalid_q && !AURORA_TX_TREADY) begin
      stall_d = (stall_q == STALL_LIMIT) ? stall_q : stall_q + 1'b1;
    end
    err_set                = '0;
    err_set[ERR_FULL_BIT]  = TX_FIFO_WREN && TX_FIFO_FULL;
    err_set[ERR_STALL_BIT] = tvalid_q && !AURORA_TX_TREADY && (stall_q == STALL_LIMIT - 1'b1);
    err_d                  = (ERR_CLR ? 2'b00 : err_q) | err_set;
  end

  // NOTE: non-blocking assignments make every flop load from pre-edge values,
  // independent of the order the statements appear in.
  always_ff @(posedge AURORA_USER_CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      idle_q    <= '0;
      beat_q    <= '0;
      tvalid_q  <= 1'b0;
      ms_q      <= '0;
      msg_cnt_q <= '0;
      stall_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
      beat_q    <= beat_d;
      tvalid_q  <= tvalid_d;
      ms_q      <= ms_d;
      msg_cnt_q <= msg_cnt_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
    end
  end

  ufc_pack_buf #(
    .FIFO_DATA_WIDTH  (FIFO_DATA_WIDTH),
    .AURORA_DATA_WIDTH(AURORA_DATA_WIDTH),
    .MAX_BEATS        (MAX_BEATS)
  ) u_pack_buf (
    .clk_i    (AURORA_USER_CLK),
    .clr_i    (buf_clr | RESET),
    .wr_en_i  (rden),
    .wr_slot_i(SLOT_W'(count_q)),
    .wr_data_i(RX_FIFO_Q),
    .rd_beat_i(beat_q),
    .rd_data_o(AURORA_TX_TDATA)
  );

endmodule

// File: tb/tb_ufc_fifo_bridge.sv
// Self-checking bench for ufc_fifo_bridge with default parameters: RX vector
// table, directed TX sequences and randomized bursts against a message model.
module tb_ufc_fifo_bridge;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_req;
  logic [7:0]  tx_ms;
  logic        tready;
  logic [63:0] tdata;
  logic        tvalid;
  logic [63:0] rx_tdata;
  logic [7:0]  rx_tkeep;
  logic        rx_tvalid;
  logic        fifo_clk;
  logic [63:0] txf_q;
  logic [5:0]  txf_nwords;
  logic        txf_wren;
  logic        txf_full;
  logic [31:0] rx_fifo_q;
  logic        rx_fifo_rden;
  logic        rx_fifo_empty;
  logic        err_clr;
  logic [1:0]  err;
  logic [15:0] msg_cnt;

  always #5 clk = ~clk;

  ufc_fifo_bridge dut (
    .AURORA_USER_CLK (clk),
    .RESET           (rst),
    .AURORA_TX_REQ   (tx_req),
    .AURORA_TX_MS    (tx_ms),
    .AURORA_TX_TREADY(tready),
    .AURORA_TX_TDATA (tdata),
    .AURORA_TX_TVALID(tvalid),
    .AURORA_RX_TDATA (rx_tdata),
    .AURORA_RX_TKEEP (rx_tkeep),
    .AURORA_RX_TVALID(rx_tvalid),
    .FIFO_CLK        (fifo_clk),
    .TX_FIFO_Q       (txf_q),
    .TX_FIFO_NWORDS  (txf_nwords),
    .TX_FIFO_WREN    (txf_wren),
    .TX_FIFO_FULL    (txf_full),
    .RX_FIFO_Q       (rx_fifo_q),
    .RX_FIFO_RDEN    (rx_fifo_rden),
    .RX_FIFO_EMPTY   (rx_fifo_empty),
    .ERR_CLR         (err_clr),
    .ERR             (err),
    .MSG_CNT         (msg_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] fifo [$];
  logic [63:0] beat_obs [$];
  logic [63:0] model_beats [$];
  logic [7:0]  ms_obs [$];
  logic [7:0]  model_ms [$];
  int          req_cnt = 0;
  int          model_msgs = 0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          req_cyc = 0;
  bit          rand_ready = 1'b0;
  bit          stall_prev = 1'b0;
  bit          rst_prev = 1'b0;
  logic [63:0] tdata_prev = '0;

  typedef struct {
    logic [7:0]  keep;
    logic [63:0] data;
    logic        valid;
    logic [5:0]  nwords;
  } rx_vec_t;

  rx_vec_t rx_tab [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync_fifo();
    rx_fifo_q     = (fifo.size() > 0) ? fifo[0] : 32'h0;
    rx_fifo_empty = (fifo.size() == 0);
  endtask

  // One clock: observe mid-cycle, let the edge happen, then update the FWFT FIFO.
  task automatic step();
    bit pend;
    @(negedge clk);
    if (stall_prev && !rst_prev) begin
      check("hold_tvalid", tvalid, 1);
      check("hold_tdata", tdata, tdata_prev);
    end
    check("rden_outside_fill", rx_fifo_rden && (tx_req || tvalid), 0);
    if (tx_req) begin
      req_cnt++;
      ms_obs.push_back(tx_ms);
      req_cyc = cyc;
    end
    if (tvalid && tready) beat_obs.push_back(tdata);
    stall_prev = tvalid && !tready;
    rst_prev   = rst;
    tdata_prev = tdata;
    pend       = rx_fifo_rden;
    @(posedge clk);
    cyc++;
    #1;
    if (pend && fifo.size() > 0) begin
      void'(fifo.pop_front());
      last_pop_cyc = cyc;
    end
    sync_fifo();
    if (rand_ready) tready = 1'($urandom_range(0, 1));
    #1;
  endtask

  // Push n words at once and predict the messages: chunks of MAXW words,
  // two words per beat (low word first), zero-padded odd tail.
  task automatic push_burst(input int n, input bit rnd, input logic [31:0] base);
    logic [31:0] w [$];
    for (int i = 0; i < n; i++) begin
      logic [31:0] v;
      v = rnd ? $urandom : base + 32'(i);
      w.push_back(v);
      fifo.push_back(v);
    end
    for (int s = 0; s < n; s += MAXW) begin
      int len;
      len = (n - s < MAXW) ? n - s : MAXW;
      model_ms.push_back(8'(len * 4 - 1));
      model_msgs++;
      for (int b = 0; b < (len + 1) / 2; b++) begin
        logic [31:0] hi;
        hi = (2*b + 1 < len) ? w[s + 2*b + 1] : 32'h0;
        model_beats.push_back({hi, w[s + 2*b]});
      end
    end
    sync_fifo();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (beat_obs.size() < n && k < budget) begin
      step();
      k++;
    end
    check("beats_arrived", 64'(beat_obs.size()), 64'(n));
  endtask

  task automatic wait_tvalid(input int budget);
    int k;
    k = 0;
    while (!tvalid && k < budget) begin
      step();
      k++;
    end
    check("tvalid_seen", tvalid, 1);
  endtask

  task automatic clear_obs();
    beat_obs.delete();
    ms_obs.delete();
    model_beats.delete();
    model_ms.delete();
    req_cnt = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_nbeats"}, 64'(beat_obs.size()), 64'(model_beats.size()));
    check({tag, "_nreq"}, 64'(req_cnt), 64'(model_ms.size()));
    check({tag, "_nms"}, 64'(ms_obs.size()), 64'(model_ms.size()));
    for (int i = 0; i < beat_obs.size() && i < model_beats.size(); i++)
      check({tag, "_beat"}, beat_obs[i], model_beats[i]);
    for (int i = 0; i < ms_obs.size() && i < model_ms.size(); i++)
      check({tag, "_ms"}, ms_obs[i], model_ms[i]);
    clear_obs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pat [12];
    rst = 1'b1; tready = 1'b0; rx_tdata = '0; rx_tkeep = '0; rx_tvalid = 1'b0;
    txf_full = 1'b0; err_clr = 1'b0;
    rx_tab[0] = '{8'h00, 64'h0123_4567_89AB_CDEF, 1'b1, 6'd0};
    rx_tab[1] = '{8'h01, 64'h1111_2222_3333_4444, 1'b0, 6'd1};
    rx_tab[2] = '{8'h0F, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 6'd1};
    rx_tab[3] = '{8'h10, 64'h0000_0000_0000_0001, 1'b1, 6'd1};
    rx_tab[4] = '{8'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd2};
    rx_tab[5] = '{8'h3C, 64'h8000_0000_0000_0000, 1'b1, 6'd1};
    rx_tab[6] = '{8'h7E, 64'h5A5A_5A5A_A5A5_A5A5, 1'b1, 6'd2};
    rx_tab[7] = '{8'h80, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 6'd1};
    rx_tab[8] = '{8'hFF, 64'h1234_5678_9ABC_DEF0, 1'b1, 6'd2};
    rx_tab[9] = '{8'hF0, 64'hAAAA_5555_AAAA_5555, 1'b1, 6'd1};
    pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};

    // Reset values, with data waiting in the FIFO to prove RDEN stays low.
    fifo.push_back(32'hDEAD_0001);
    sync_fifo();
    step();
    step();
    check("rst_req", tx_req, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_err", err, 0);
    check("rst_msg_cnt", msg_cnt, 0);
    check("rst_ms", tx_ms, 0);
    check("rst_rden", rx_fifo_rden, 0);
    fifo.delete();
    sync_fifo();
    rst = 1'b0;
    step();
    clear_obs();

    // RX passthrough table.
    for (int i = 0; i < 10; i++) begin
      rx_tkeep  = rx_tab[i].keep;
      rx_tdata  = rx_tab[i].data;
      rx_tvalid = rx_tab[i].valid;
      #1;
      check("rx_q", txf_q, rx_tab[i].data);
      check("rx_wren", txf_wren, rx_tab[i].valid);
      check("rx_nwords", txf_nwords, rx_tab[i].nwords);
    end
    rx_tvalid = 1'b0;
    step();

    // Write into a full TX FIFO sets ERR[0]; ERR_CLR clears; a same-cycle set wins.
    rx_tvalid = 1'b1; rx_tkeep = 8'h0F; txf_full = 1'b1;
    #1;
    check("err0_wren", txf_wren, 1);
    check("err0_nwords", txf_nwords, 1);
    step();
    check("err0_set", err, 2'b01);
    rx_tvalid = 1'b0; txf_full = 1'b0; err_clr = 1'b1;
    step();
    check("err0_clr", err, 2'b00);
    rx_tvalid = 1'b1; txf_full = 1'b1;
    step();
    check("err0_set_wins", err, 2'b01);
    rx_tvalid = 1'b0; txf_full = 1'b0;
    step();
    err_clr = 1'b0;
    check("err0_clr2", err, 2'b00);

    // Full burst of eight words.
    tready = 1'b1;
    push_burst(8, 1'b0, 32'h1);
    wait_beats(4, 200);
    repeat (3) step();
    if (beat_obs.size() > 3) begin
      check("burst_beat0", beat_obs[0], 64'h00000002_00000001);
      check("burst_beat3", beat_obs[3], 64'h00000008_00000007);
    end
    if (ms_obs.size() > 0) check("burst_ms", ms_obs[0], 8'd31);
    check("burst_msg_cnt", msg_cnt, 16'(model_msgs));
    compare_all("burst");

    // Single word flushed by the idle timeout.
    push_burst(1, 1'b0, 32'hA5A5_A5A5);
    wait_beats(1, 100);
    check("flush_delay", 64'(req_cyc - last_pop_cyc), 64'd16);
    if (beat_obs.size() > 0) check("flush_beat", beat_obs[0], 64'h00000000_A5A5A5A5);
    repeat (3) step();
    compare_all("flush");

    // Backpressure during SEND.
    tready = 1'b0;
    push_burst(8, 1'b0, 32'h100);
    wait_tvalid(50);
    for (int i = 0; i < 12; i++) begin
      tready = pat[i][0];
      step();
    end
    tready = 1'b1;
    wait_beats(4, 50);
    repeat (3) step();
    check("bp_err", err, 2'b00);
    compare_all("bp");

    // 1024 stalled cycles raise ERR[1], not 1023.
    tready = 1'b0;
    push_burst(2, 1'b0, 32'h200);
    wait_tvalid(100);
    repeat (1023) step();
    check("stall_1023", err[1], 0);
    step();
    check("stall_1024", err[1], 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("stall_clr", err, 2'b00);
    tready = 1'b1;
    wait_beats(1, 20);
    repeat (3) step();
    compare_all("stall");
    check("msg_cnt_pre_rst", msg_cnt, 16'(model_msgs));

    // Reset while beat 1 is on the bus.
    tready = 1'b0;
    push_burst(8, 1'b0, 32'h300);
    wait_tvalid(100);
    tready = 1'b1;
    step();
    tready = 1'b0;
    check("mid_beat1", tdata, {32'h303, 32'h302});
    rst = 1'b1;
    step();
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_req", tx_req, 0);
    check("mid_rst_msg_cnt", msg_cnt, 0);
    check("mid_rst_ms", tx_ms, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_rden", rx_fifo_rden, 0);
    rst = 1'b0;
    clear_obs();
    model_msgs = 0;
    push_burst(8, 1'b0, 32'h400);
    tready = 1'b1;
    wait_beats(4, 200);
    repeat (3) step();
    check("post_rst_msg_cnt", msg_cnt, 16'(model_msgs));
    compare_all("post_rst");

    // Random bursts with random TREADY.
    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      push_burst(int'($urandom_range(1, 20)), 1'b1, 32'h0);
      wait_beats(model_beats.size(), 3000);
      repeat (4) step();
    end
    rand_ready = 1'b0;
    tready = 1'b1;
    step();
    check("rand_msg_cnt", msg_cnt, 16'(model_msgs));
    check("rand_err", err, 2'b00);
    compare_all("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ufc_fifo_bridge.md
UFC_FIFO_BRIDGE -- requirements
Module: ufc_fifo_bridge

Interface
REQ-001 SHALL have parameter FIFO_DATA_WIDTH, default 32, width of one FIFO word.
REQ-002 SHALL have parameter AURORA_DATA_WIDTH, default 64, UFC beat width; an integer multiple of FIFO_DATA_WIDTH, giving WPB = AURORA_DATA_WIDTH/FIFO_DATA_WIDTH words per beat.
REQ-003 SHALL have parameter MAX_BEATS, default 4, range 1..32, maximum beats per UFC message; MAX_WORDS = MAX_BEATS*WPB; message bytes SHALL be at most 256.
REQ-004 SHALL have parameter FLUSH_TIMEOUT, default 16, number of idle cycles before a partial message is sent.
REQ-005 SHALL have ports: AURORA_USER_CLK in 1, sole clock; RESET in 1, synchronous active-high reset.
REQ-006 SHALL have ports: AURORA_TX_REQ out 1; AURORA_TX_MS out 8, message bytes minus 1; AURORA_TX_TREADY in 1; AURORA_TX_TDATA out AURORA_DATA_WIDTH; AURORA_TX_TVALID out 1.
REQ-007 SHALL have ports: AURORA_RX_TDATA in AURORA_DATA_WIDTH; AURORA_RX_TKEEP in AURORA_DATA_WIDTH/8; AURORA_RX_TVALID in 1.
REQ-008 SHALL have ports: FIFO_CLK out 1, equal to AURORA_USER_CLK; TX_FIFO_Q out AURORA_DATA_WIDTH; TX_FIFO_NWORDS out 6, number of valid words in the beat; TX_FIFO_WREN out 1; TX_FIFO_FULL in 1.
REQ-009 SHALL have ports: RX_FIFO_Q in FIFO_DATA_WIDTH, first-word-fall-through; RX_FIFO_RDEN out 1; RX_FIFO_EMPTY in 1.
REQ-010 SHALL have ports: ERR_CLR in 1; ERR out 2, sticky; MSG_CNT out 16, count of sent messages.

Function
REQ-011 The RX path SHALL be combinational: TX_FIFO_Q = AURORA_RX_TDATA, TX_FIFO_WREN = AURORA_RX_TVALID, and TX_FIFO_NWORDS = number of set TKEEP bytes divided by FIFO_DATA_WIDTH/8, rounded up.
REQ-012 The TX FSM SHALL have states IDLE, FILL, REQ and SEND.
REQ-013 IDLE: when RX_FIFO_EMPTY is 0 the FSM SHALL go to FILL with the word count at 0 and the idle counter at 0.
REQ-014 FILL: RX_FIFO_RDEN SHALL be combinational and equal to (FILL and not RX_FIFO_EMPTY and count < MAX_WORDS); on each pop, RX_FIFO_Q SHALL be stored into pack slot[count], count SHALL increment and the idle counter SHALL clear.
REQ-015 FILL: on each cycle without a pop the idle counter SHALL increment, saturating.
REQ-016 FILL SHALL exit to REQ when count reaches MAX_WORDS, or when count > 0 and the idle counter reaches FLUSH_TIMEOUT.
REQ-017 Pack slot w SHALL occupy beat w/WPB at bit offset (w mod WPB)*FIFO_DATA_WIDTH, with unused slots in the last beat driven to 0.
REQ-018 REQ: AURORA_TX_REQ SHALL be 1 for exactly one cycle; AURORA_TX_MS SHALL be count*FIFO_DATA_WIDTH/8-1, registered on entry to REQ and held stable until SEND exits.
REQ-019 SEND: AURORA_TX_TVALID SHALL be 1, starting the cycle after REQ; TDATA SHALL show the current beat; the beat SHALL advance on TVALID and TREADY both being 1.
REQ-020 TDATA and TVALID SHALL stay stable while TREADY is 0.
REQ-021 Acceptance of beat ceil(count/WPB)-1 SHALL increment MSG_CNT (wrapping), drop TVALID the next cycle, and return the FSM to IDLE.
REQ-022 No RX_FIFO_RDEN SHALL be asserted outside FILL.
REQ-023 ERR[0] SHALL set when TX_FIFO_WREN and TX_FIFO_FULL are both 1.
REQ-024 ERR[1] SHALL set when TVALID stays 1 without TREADY for 1024 consecutive cycles.
REQ-025 ERR_CLR SHALL clear ERR; a set condition occurring in the same cycle as ERR_CLR SHALL win.

Reset
REQ-026 While RESET is 1 on a clock edge: state SHALL become IDLE; AURORA_TX_REQ, AURORA_TX_TVALID, ERR, MSG_CNT, count, idle counter and beat index SHALL become 0; AURORA_TX_MS SHALL become 0.
REQ-027 RESET mid-message SHALL discard words already popped into the pack buffer, and RX_FIFO_RDEN SHALL be 0 during reset.

Structure
REQ-028 The FSM state encoding, the ERR bit indices and the 1024-cycle stall limit SHALL live in a shared package, ufc_pkg.
REQ-029 The pack buffer plus beat mux SHALL be one sub-module, ufc_pack_buf (write slot, read beat, clear).

Verification
REQ-030 Burst test: 8 words 0x1..0x8 preloaded, TREADY=1 -> one REQ with MS=31; beats 0x00000002_00000001 through 0x00000008_00000007; MSG_CNT=1.
REQ-031 Timeout flush: a single word 0xA5A5A5A5 -> REQ 16 cycles after the pop with MS=3; beat 0x00000000_A5A5A5A5.
REQ-032 Backpressure test: TREADY toggled 1-0-0-1 during SEND -> TDATA held; no beat dropped or duplicated; ERR[1]=0.
REQ-033 RX test: RX beat with TKEEP=0x0F and TX_FIFO_FULL=1 -> WREN=1, NWORDS=1, ERR[0]=1 next cycle; ERR_CLR -> ERR=0.
REQ-034 Reset test: RESET during SEND of beat 1 -> outputs at reset values the next cycle; the next message starts from fresh FIFO data.
